// File: rtl/uart_cmd_ctrl_if.sv
// RX-FIFO read port and UART TX handshake used by the command controller.
// The controller plugs into the slave side; the FIFO/transmitter side is the master.
interface uart_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  i_fifo_empty;
  logic                  o_fifo_rd;
  logic                  i_tx_busy;
  logic                  o_tx_start;
  logic [DATA_WIDTH-1:0] o_tx_data;

  modport master (
    output i_fifo_data, i_fifo_empty, i_tx_busy,
    input  o_fifo_rd, o_tx_start, o_tx_data
  );

  modport slave (
    input  i_fifo_data, i_fifo_empty, i_tx_busy,
    output o_fifo_rd, o_tx_start, o_tx_data
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Run/stop/clear counter controller driven by buttons and UART command bytes,
// with a single-slot echo path back to the UART transmitter.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 14,
  parameter int CNT_MAX    = 9999,
  parameter int TICK_DIV   = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_cmd_ctrl_if.slave       bus,
  input  logic                 btn_run,
  input  logic                 btn_clr,
  input  logic                 btn_dir,
  output logic                 o_run_on,
  output logic                 o_clr_on,
  output logic                 o_dir,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_echo_ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_TOP    = CNT_WIDTH'(CNT_MAX);
  localparam logic [DATA_WIDTH-1:0] CH_RU = DATA_WIDTH'(8'h52);
  localparam logic [DATA_WIDTH-1:0] CH_RL = DATA_WIDTH'(8'h72);
  localparam logic [DATA_WIDTH-1:0] CH_CU = DATA_WIDTH'(8'h43);
  localparam logic [DATA_WIDTH-1:0] CH_CL = DATA_WIDTH'(8'h63);
  localparam logic [DATA_WIDTH-1:0] CH_DU = DATA_WIDTH'(8'h44);
  localparam logic [DATA_WIDTH-1:0] CH_DL = DATA_WIDTH'(8'h64);

  typedef enum logic [1:0] {STOP, RUN, CLEAR} state_e;
  typedef enum logic       {RD_IDLE, RD_WAIT} rd_e;

  state_e                state_q, state_d;
  rd_e                   rd_q, rd_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] rx_byte;
  logic is_run, is_clr, is_dir, is_cmd;
  logic run_ev, clr_ev, dir_ev, tick, tx_busy;

  // The pop strobe is registered: the byte is decoded during the strobe cycle
  // (still at the FIFO head) and the following cycle lets the empty flag settle.
  always_comb begin
    rx_byte = bus.i_fifo_data;
    is_run  = fifo_rd_q && (rx_byte == CH_RU || rx_byte == CH_RL);
    is_clr  = fifo_rd_q && (rx_byte == CH_CU || rx_byte == CH_CL);
    is_dir  = fifo_rd_q && (rx_byte == CH_DU || rx_byte == CH_DL);
    is_cmd  = is_run || is_clr || is_dir;
    run_ev  = btn_run || is_run;
    clr_ev  = (btn_clr || is_clr) && !run_ev;
    dir_ev  = btn_dir || is_dir;
    tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
    // A strobe already on the wire counts as busy: the transmitter only sees it next cycle.
    tx_busy = bus.i_tx_busy || tx_start_q;
  end

  always_comb begin
    rd_d      = rd_q;
    fifo_rd_d = 1'b0;
    if (rd_q == RD_IDLE) begin
      if (!bus.i_fifo_empty) begin
        fifo_rd_d = 1'b1;
        rd_d      = RD_WAIT;
      end
    end else begin
      rd_d = RD_IDLE;
    end

    state_d = state_q;
    case (state_q)
      STOP:    if (run_ev) state_d = RUN; else if (clr_ev) state_d = CLEAR;
      RUN:     if (run_ev) state_d = STOP;
      default: state_d = STOP;
    endcase

    dir_d   = dir_q ^ dir_ev;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    if (state_q == CLEAR) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      if (dir_q) cnt_d = (cnt_q == '0) ? CNT_TOP : cnt_q - 1'b1;
      else       cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
    end

    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    if (pend_vld_q && !tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = pend_q;
      pend_vld_d = 1'b0;
    end
    // A free transmitter drains the slot this cycle, so a new echo can take it.
    if (is_cmd) begin
      if (!tx_busy && !pend_vld_q) begin
        tx_start_d = 1'b1;
        tx_data_d  = rx_byte;
      end else if (!pend_vld_q || !tx_busy) begin
        pend_vld_d = 1'b1;
        pend_d     = rx_byte;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= STOP;
      rd_q       <= RD_IDLE;
      fifo_rd_q  <= 1'b0;
      presc_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      fifo_rd_q  <= fifo_rd_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_run_on       = (state_q == RUN);
  assign o_clr_on       = (state_q == CLEAR);
  assign o_dir          = dir_q;
  assign o_count        = cnt_q;
  assign o_echo_ovf     = ovf_q;
  assign bus.o_fifo_rd  = fifo_rd_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized + directed bench for uart_cmd_ctrl: FIFO and transmitter models drive
// the DUT, a negedge monitor checks outputs and echoes against a reference model.
module tb_uart_cmd_ctrl;
  localparam int DW = 8, CW = 4, CMAX = 9, TDIV = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic btn_run = 1'b0, btn_clr = 1'b0, btn_dir = 1'b0;
  logic o_run_on, o_clr_on, o_dir, o_echo_ovf;
  logic [CW-1:0] o_count;

  uart_cmd_ctrl_if #(.DATA_WIDTH(DW)) bus();

  uart_cmd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .CNT_MAX(CMAX), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .btn_run(btn_run), .btn_clr(btn_clr), .btn_dir(btn_dir),
    .o_run_on(o_run_on), .o_clr_on(o_clr_on), .o_dir(o_dir),
    .o_count(o_count), .o_echo_ovf(o_echo_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] echo_q[$];
  bit pop_pend = 0, saw_start = 0, hold_busy = 0, prev_rd = 0;
  int tx_cnt = 0, n_pops = 0, n_starts = 0;
  logic [7:0] last_tx = 8'h00;
  // reference state: 0=STOP 1=RUN 2=CLEAR
  int m_state = 0, m_presc = 0, m_cnt = 0;
  bit m_dir = 0, m_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.i_fifo_empty = (fifo_q.size() == 0);
    bus.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.i_tx_busy    = hold_busy || (tx_cnt > 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  // Advance to 1ns after the next rising edge, applying FIFO pops and transmitter busy.
  task automatic tick_cyc(input int n);
    logic [7:0] tmp;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        tmp = fifo_q.pop_front();
        pop_pend = 0;
      end
      if (saw_start) begin
        tx_cnt = $urandom_range(1, 5);
        saw_start = 0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
      end
      btn_run = 0; btn_clr = 0; btn_dir = 0;
      drive_fifo();
    end
  endtask

  always @(negedge clk) begin : mon
    logic [7:0] b, e;
    bit dec, run, clr, dr, recog, tick;
    int ns, np, nc;
    if (!reset) begin
      chk("reset_outputs",
          32'({o_run_on, o_clr_on, o_dir, o_echo_ovf, o_count, bus.o_fifo_rd, bus.o_tx_start, bus.o_tx_data}), 0);
      m_state = 0; m_presc = 0; m_cnt = 0; m_dir = 0; m_ovf = 0;
      echo_q.delete();
      saw_start = 0; prev_rd = 0; pop_pend = 0;
    end else begin
      dec = bus.o_fifo_rd;
      b = 8'h00;
      if (dec) begin
        chk("rd_nonempty", 32'(bus.i_fifo_empty), 0);
        chk("rd_spacing", 32'(prev_rd), 0);
        if (fifo_q.size() != 0) begin
          b = fifo_q[0];
          pop_pend = 1;
        end
        n_pops++;
      end
      prev_rd = dec;
      if (bus.o_tx_start) begin
        n_starts++;
        saw_start = 1;
        last_tx = bus.o_tx_data;
        chk("start_while_busy", 32'(bus.i_tx_busy), 0);
        chk("echo_expected", 32'(echo_q.size() != 0), 1);
        if (echo_q.size() != 0) begin
          e = echo_q.pop_front();
          chk("echo_data", 32'(bus.o_tx_data), 32'(e));
        end
      end
      chk("outputs", 32'({o_run_on, o_clr_on, o_dir, o_echo_ovf, o_count}),
          32'({m_state == 1, m_state == 2, m_dir, m_ovf, CW'(m_cnt)}));

      run   = btn_run || (dec && (b == 8'h52 || b == 8'h72));
      clr   = btn_clr || (dec && (b == 8'h43 || b == 8'h63));
      dr    = btn_dir || (dec && (b == 8'h44 || b == 8'h64));
      recog = dec && (b == 8'h52 || b == 8'h72 || b == 8'h43 || b == 8'h63 || b == 8'h44 || b == 8'h64);
      // one waiting echo allowed; a second is kept only if the transmitter frees the slot now
      if (recog) begin
        if (echo_q.size() == 0 || (!bus.i_tx_busy && !bus.o_tx_start)) echo_q.push_back(b);
        else m_ovf = 1;
      end
      tick = (m_state == 1) && (m_presc == TDIV - 1);
      nc = m_cnt;
      if (m_state == 2) nc = 0;
      else if (tick) nc = m_dir ? (m_cnt + CMAX) % (CMAX + 1) : (m_cnt + 1) % (CMAX + 1);
      np = (m_state == 1) ? (m_presc + 1) % TDIV : (m_state == 2) ? 0 : m_presc;
      case (m_state)
        0:       ns = run ? 1 : (clr ? 2 : 0);
        1:       ns = run ? 0 : 1;
        default: ns = 0;
      endcase
      m_state = ns; m_presc = np; m_cnt = nc;
      m_dir = m_dir ^ dr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, p0, clr_seen;
    logic [7:0] tbl [0:7];
    tbl[0] = 8'h52; tbl[1] = 8'h72; tbl[2] = 8'h43; tbl[3] = 8'h63;
    tbl[4] = 8'h44; tbl[5] = 8'h64; tbl[6] = 8'h78; tbl[7] = 8'h00;
    drive_fifo();
    #2;
    chk("reset_state", 32'({o_run_on, o_clr_on, o_dir, o_echo_ovf, o_count, bus.o_fifo_rd, bus.o_tx_start}), 0);
    tick_cyc(3);
    reset = 1'b1;

    // 'r' starts the counter; ticks every TDIV cycles
    push(8'h72);
    for (int i = 0; i < 10 && !o_run_on; i++) tick_cyc(1);
    chk("run_entry", 32'(o_run_on), 1);
    tick_cyc(4); chk("count_at_4", 32'(o_count), 1);
    tick_cyc(4); chk("count_at_8", 32'(o_count), 2);
    tick_cyc(4); chk("count_at_12", 32'(o_count), 3);
    chk("echo_r", 32'(last_tx), 32'h72);

    // wrap up at CNT_MAX, then 'd' and wrap down from 0
    for (int i = 0; i < 40 && o_count != 4'(CMAX); i++) tick_cyc(1);
    chk("reach_max", 32'(o_count), CMAX);
    for (int i = 0; i < 8 && o_count == 4'(CMAX); i++) tick_cyc(1);
    chk("wrap_up", 32'(o_count), 0);
    push(8'h64);
    for (int i = 0; i < 8 && o_count == 4'd0; i++) tick_cyc(1);
    chk("dir_after_d", 32'(o_dir), 1);
    chk("wrap_down", 32'(o_count), CMAX);

    // 'c' ignored in RUN, then 'r','c' -> STOP, CLEAR one cycle, STOP
    push(8'h63);
    tick_cyc(6);
    chk("c_in_run", 32'({o_run_on, o_clr_on}), 32'b10);
    push(8'h72); push(8'h63);
    clr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick_cyc(1);
      if (o_clr_on) clr_seen++;
    end
    chk("clear_cycles", clr_seen, 1);
    chk("count_cleared", 32'(o_count), 0);
    chk("stop_after_clear", 32'(o_run_on), 0);

    // btn_run together with decoded 'R' toggles once, echo once
    tick_cyc(10);
    s0 = n_starts;
    push(8'h52);
    tick_cyc(1);
    chk("pop_strobe", 32'(bus.o_fifo_rd), 1);
    btn_run = 1;
    tick_cyc(1);
    chk("run_once", 32'(o_run_on), 1);
    tick_cyc(10);
    chk("run_stays", 32'(o_run_on), 1);
    chk("echo_once", n_starts - s0, 1);

    // transmitter held busy: 'r' pends, 'd' dropped, 'x' discarded
    for (int i = 0; i < 20 && (bus.i_tx_busy || bus.o_tx_start); i++) tick_cyc(1);
    hold_busy = 1; drive_fifo();
    p0 = n_pops; s0 = n_starts;
    push(8'h72); push(8'h64); push(8'h78);
    tick_cyc(14);
    chk("busy_pops", n_pops - p0, 3);
    chk("ovf_set", 32'(o_echo_ovf), 1);
    chk("no_start_busy", n_starts - s0, 0);
    hold_busy = 0; drive_fifo();
    tick_cyc(6);
    chk("release_echo", n_starts - s0, 1);
    chk("release_data", 32'(last_tx), 32'h72);
    chk("ovf_sticky", 32'(o_echo_ovf), 1);

    // async reset in RUN at count 5, then pop on the first edge after release
    if (!o_run_on) push(8'h72);
    for (int i = 0; i < 300 && !(o_run_on && o_count == 4'd5); i++) tick_cyc(1);
    chk("reach5", 32'({o_run_on, o_count}), 32'h15);
    reset = 1'b0;
    #1;
    chk("async_reset",
        32'({o_run_on, o_clr_on, o_dir, o_echo_ovf, o_count, bus.o_fifo_rd, bus.o_tx_start, bus.o_tx_data}), 0);
    push(8'h43);
    tick_cyc(3);
    reset = 1'b1;
    tick_cyc(1);
    chk("first_pop", 32'(bus.o_fifo_rd), 1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      tick_cyc(1);
      if ($urandom_range(0, 29) == 0) begin
        if (hold_busy) hold_busy = 0;
        else if (!bus.o_tx_start) hold_busy = 1;
      end
      btn_run = ($urandom_range(0, 24) == 0);
      btn_clr = ($urandom_range(0, 24) == 0);
      btn_dir = ($urandom_range(0, 24) == 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 7) fifo_q.push_back(8'($urandom));
        else fifo_q.push_back(tbl[$urandom_range(0, 6)]);
      end
      drive_fifo();
    end

    hold_busy = 0; drive_fifo();
    tick_cyc(60);
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_echo", echo_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
- REQ-001 Parameter DATA_WIDTH, default 8: width of the command bytes read from the RX FIFO and echoed to TX.
- REQ-002 Parameter CNT_WIDTH, default 14: width of the counter output.
- REQ-003 Parameter CNT_MAX, default 9999: terminal count value, which SHALL be less than 2^CNT_WIDTH.
- REQ-004 Parameter TICK_DIV, default 1_000_000: clk cycles per count tick, which SHALL be at least 1.
- REQ-005 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
- REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-007 Port i_fifo_data, input, DATA_WIDTH bits: head-of-FIFO byte, show-ahead (valid whenever i_fifo_empty=0).
- REQ-008 Port i_fifo_empty, input, 1 bit: RX FIFO empty flag.
- REQ-009 Port o_fifo_rd, output, 1 bit: one-cycle pop strobe to the RX FIFO.
- REQ-010 Ports btn_run, btn_clr and btn_dir, input, 1 bit each: debounced single-cycle pulses.
- REQ-011 Port i_tx_busy, input, 1 bit: high while the UART transmitter is busy.
- REQ-012 Port o_tx_start, output, 1 bit: one-cycle transmit strobe.
- REQ-013 Port o_tx_data, output, DATA_WIDTH bits: echo byte, valid while o_tx_start=1.
- REQ-014 Port o_run_on, output, 1 bit: high in state RUN.
- REQ-015 Port o_clr_on, output, 1 bit: high in state CLEAR.
- REQ-016 Port o_dir, output, 1 bit: count direction, 0=up, 1=down.
- REQ-017 Port o_count, output, CNT_WIDTH bits: current count value.
- REQ-018 Port o_echo_ovf, output, 1 bit: sticky flag indicating a dropped echo.

Function
- REQ-019 The control FSM SHALL have states STOP, RUN and CLEAR.
- REQ-020 The control FSM SHALL transition on the following events:
  - STOP--run-->RUN
  - RUN--run-->STOP
  - STOP--clr-->CLEAR
  - CLEAR-->STOP unconditionally after 1 cycle
  - clr in RUN is ignored.
- REQ-021 The run event SHALL be btn_run OR a decoded 'R'/'r' (8'h52/8'h72); the clr event SHALL be btn_clr OR 'C'/'c' (8'h43/8'h63); the dir event SHALL be btn_dir OR 'D'/'d' (8'h44/8'h64).
- REQ-022 Events of the same kind arriving from the button and the UART in the same cycle SHALL act once.
- REQ-023 When run and clr occur in the same cycle, run SHALL be applied and clr discarded.
- REQ-024 The dir event SHALL toggle o_dir in any state and SHALL be independent of run and clr.
- REQ-025 The reader sub-FSM SHALL have states RD_IDLE and RD_WAIT.
- REQ-026 In RD_IDLE with i_fifo_empty=0, the block SHALL assert o_fifo_rd for exactly 1 cycle, decode i_fifo_data in that same cycle, and go to RD_WAIT.
- REQ-027 RD_WAIT SHALL last 1 cycle with o_fifo_rd=0, then return to RD_IDLE.
- REQ-028 The pop rate SHALL therefore be at most 1 byte per 2 cycles.
- REQ-029 o_fifo_rd SHALL never be asserted while i_fifo_empty=1.
- REQ-030 Unrecognised bytes SHALL be popped and discarded, generating no event and no echo.
- REQ-031 The prescaler SHALL count 0..TICK_DIV-1 in RUN only, generating a 1-cycle tick on wrap to 0.
- REQ-032 The prescaler SHALL hold in STOP and SHALL be zeroed in CLEAR.
- REQ-033 On a tick with o_dir=0, o_count SHALL increment, wrapping CNT_MAX->0.
- REQ-034 On a tick with o_dir=1, o_count SHALL decrement, wrapping 0->CNT_MAX.
- REQ-035 A dir toggle coinciding with a tick SHALL take effect from the next tick.
- REQ-036 In CLEAR, o_count SHALL be 0 one cycle after entry and SHALL be held there; o_dir SHALL be unchanged.
- REQ-037 Each recognised UART command byte SHALL be echoed unchanged; button events SHALL not be echoed.
- REQ-038 When i_tx_busy=0 at decode, o_tx_start SHALL pulse for 1 cycle in the cycle after decode, with o_tx_data holding the byte.
- REQ-039 When i_tx_busy=1 at decode, the byte SHALL be held in a single pending register and sent on the first cycle with i_tx_busy=0.
- REQ-040 A new echo arriving while one is pending SHALL be dropped, and o_echo_ovf SHALL be set.
- REQ-041 o_echo_ovf SHALL clear only on reset.
- REQ-042 o_tx_start SHALL never be asserted while i_tx_busy=1.

Reset
- REQ-043 When reset=0, asynchronously and independent of clk: FSM=STOP, reader=RD_IDLE, prescaler=0, pending register empty.
- REQ-044 When reset=0, asynchronously and independent of clk: o_count=0, o_dir=0, o_run_on=0, o_clr_on=0, o_fifo_rd=0, o_tx_start=0, o_tx_data=0, o_echo_ovf=0.
- REQ-045 Reset deassertion SHALL be synchronous to clk; the first pop SHALL be allowed on the first rising edge with reset=1.
- REQ-046 A reset asserted mid-pop or mid-echo SHALL abort that pop or echo; no strobe SHALL be asserted after release until new input arrives.

Verification
- REQ-047 With TICK_DIV=4, FIFO holding 'r' -> 1 pop, echo 8'h72, o_run_on=1; o_count reaches 1,2,3 at 4, 8 and 12 cycles after RUN entry.
- REQ-048 With CNT_MAX=9, RUN, o_count=9, dir up, tick -> 0; after a 'd' command and a tick from 0 -> 9.
- REQ-049 In RUN, 'c' -> ignored (o_clr_on stays 0, echo still sent); then 'r','c' -> STOP, then CLEAR for 1 cycle, o_count=0, then STOP.
- REQ-050 btn_run and 'R' in the same cycle from STOP -> single toggle to RUN; 'R' echoed once.
- REQ-051 i_tx_busy=1 held, FIFO receives 'r','d','x' -> 3 pops, 'x' not echoed; 'd' dropped, o_echo_ovf=1; on busy release 8'h72 sent once.
- REQ-052 Reset pulled low during RUN with o_count=5 -> all outputs 0 immediately without a clk edge; FIFO non-empty -> pop asserted on the first edge after release.
